ones_pattern_gen: RTL

Sequential generator of 7-bit words with a requested population count. It is the inverse of the team's ones-counting datapath: it takes a count k and emits, one per handshake, every 7-bit word containing exactly k ones, in ascending numeric order. It sits in front of the ones counter as a stimulus and self-check source, and as a general combination enumerator.

---
 rtl/ones_gen_pkg.sv | 46 ++++
 rtl/ones_next_comb.sv | 27 ++
 rtl/ones_pattern_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/ones_gen_pkg.sv
// Shared widths, FSM state, beat payload and pattern helpers for the
// fixed-popcount word generator.
package ones_gen_pkg;

    localparam int unsigned WIDTH = 7;
    localparam int unsigned CW    = $clog2(WIDTH + 1);
    localparam int unsigned IW    = 6;
    // Shift amount of Gosper's step reaches tz(c)+2 <= WIDTH+1
    localparam int unsigned SW    = $clog2(WIDTH + 3);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic [IW-1:0]    index;
    } beat_t;

    // k ones in the LSBs: smallest word with popcount k
    function automatic logic [WIDTH-1:0] first_pattern(input logic [CW-1:0] k);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(k)) p[i] = 1'b1;
        end
        return p;
    endfunction

    // k ones in the MSBs: largest word with popcount k
    function automatic logic [WIDTH-1:0] top_pattern(input logic [CW-1:0] k);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i >= int'(WIDTH) - int'(k)) p[i] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] k);
        if (int'(k) > int'(WIDTH)) return CW'(WIDTH);
        return k;
    endfunction

endpackage

// File: rtl/ones_next_comb.sv
// Gosper's step: next larger word with the same number of ones.
// Purely combinational; the caller never presents the top pattern.
module ones_next_comb
    import ones_gen_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] next_x
);

    logic [WIDTH-1:0] low_c;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [SW-1:0]    shamt_c;

    always_comb begin
        low_c   = x & (~x + WIDTH'(1));
        sum_c   = {1'b0, x} + {1'b0, low_c};
        diff_c  = {1'b0, x} ^ sum_c;
        // low_c is one-hot, so this resolves to tz(low_c)+2
        shamt_c = SW'(2);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (low_c[i]) shamt_c = SW'(i + 2);
        end
        next_x  = WIDTH'(sum_c | (diff_c >> shamt_c));
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates every WIDTH-bit word with a requested popcount in ascending
// order, one word per output handshake.
module ones_pattern_gen
    import ones_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [CW-1:0]    req_count,
    output logic             req_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [IW-1:0]    out_index,
    output logic             busy
);

    state_t           state_q, state_d;
    beat_t            beat_q, beat_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] next_word_c;

    ones_next_comb u_next (
        .x      (beat_q.word),
        .next_x (next_word_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            k_q     <= k_d;
        end
    end

    // Next state: accept in IDLE, advance or finish on each output handshake
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    k_d          = clamp_count(req_count);
                    beat_d.word  = first_pattern(k_d);
                    beat_d.index = '0;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d.word  = next_word_c;
                        beat_d.index = beat_q.index + IW'(1);
                    end
                end
            end
        endcase
    end

    // Outputs decoded from registers only
    always_comb begin
        req_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (beat_q.word == top_pattern(k_q));
            end
        endcase
    end

    assign d_out     = beat_q.word;
    assign out_index = beat_q.index;

endmodule
